oflow_core_write_sequencer: RTL and testbench

//  Parametrised write-back sequencer for the oflow core. After conflict resolve it walks the PE array row by row.

---
 rtl/oflow_core_write_pkg.sv | 48 ++++
 rtl/oflow_core_write_sequencer_row_split.sv | 55 +++++
 rtl/oflow_core_write_sequencer.sv | 156 +++++++++++++++
 tb/tb_oflow_core_write_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_core_write_pkg.sv
// ---------------------------------------------------------------------------
// oflow_core_write_pkg
// Shared types and helpers for the oflow core write-back sequencer.
//  - wr_state_t   : sequencer FSM states
//  - row_w_f      : row counter width for a given frame size and row length
//  - grp_w_f      : group counter width for a given row length and beat width
//  - rem_w_f      : width needed to hold N % PE_NUM
//  - lane_mask_f  : LSB-filled mask of 'count' ones, clipped to 'lanes'
// ---------------------------------------------------------------------------
package oflow_core_write_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      ROW  = 3'd2,
      BEAT = 3'd3,
      DONE = 3'd4
   } wr_state_t;

   // Every derived width is forced to at least 1 bit so degenerate
   // parameter sets still produce legal vectors.
   function automatic int max1_f(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   // Row counter must reach full_rows itself (the partial row index).
   function automatic int row_w_f(input int bbox_w, input int pe_num);
      return max1_f($clog2(((1 << bbox_w) - 1) / pe_num + 1));
   endfunction

   function automatic int grp_w_f(input int pe_num, input int lanes);
      return max1_f($clog2((pe_num + lanes - 1) / lanes));
   endfunction

   function automatic int rem_w_f(input int pe_num);
      return max1_f($clog2(pe_num));
   endfunction

   function automatic logic [31:0] lane_mask_f(input int count, input int lanes);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) begin
         if ((i < count) && (i < lanes)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/oflow_core_write_sequencer_row_split.sv
// ---------------------------------------------------------------------------
// oflow_bbox_row_split
// Splits a latched bbox count N into full PE rows and the partial last row.
// Results are registered on 'load' and held until the next load.
// Ports:
//  clk, reset_N   clock, async active-low reset
//  load           capture enable (sequencer LOAD state)
//  n              latched bbox count
//  full_rows      N / PE_NUM
//  rem            N % PE_NUM
//  rem_last_grp   index of the last group in the partial row (ceil(rem/LANES)-1)
// ---------------------------------------------------------------------------
module oflow_bbox_row_split #(
   parameter int PE_NUM = 22,
   parameter int LANES  = 4,
   parameter int BBOX_W = 10,
   parameter int ROW_W  = 6,
   parameter int GRP_W  = 3,
   parameter int REM_W  = 5
) (
   input  logic              clk,
   input  logic              reset_N,
   input  logic              load,
   input  logic [BBOX_W-1:0] n,
   output logic [ROW_W-1:0]  full_rows,
   output logic [REM_W-1:0]  rem,
   output logic [GRP_W-1:0]  rem_last_grp
);

   logic [BBOX_W-1:0] quot;
   logic [BBOX_W-1:0] modv;
   logic [BBOX_W-1:0] last_grp_calc;

   // Division by a constant row length; last group index is stored as
   // (groups - 1) so it always fits GRP_W even when groups is a power of two.
   always_comb begin
      quot          = n / BBOX_W'(PE_NUM);
      modv          = n % BBOX_W'(PE_NUM);
      last_grp_calc = '0;
      if (modv != '0) last_grp_calc = (modv - BBOX_W'(1)) / BBOX_W'(LANES);
   end

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         full_rows    <= '0;
         rem          <= '0;
         rem_last_grp <= '0;
      end else if (load) begin
         full_rows    <= ROW_W'(quot);
         rem          <= REM_W'(modv);
         rem_last_grp <= GRP_W'(last_grp_calc);
      end
   end

endmodule

// File: rtl/oflow_core_write_sequencer.sv
// ---------------------------------------------------------------------------
// oflow_core_write_sequencer
// Walks the PE array row by row, LANES PEs per beat, presenting
// (row_sel, grp_sel, lane_mask) to the frame buffer under valid/ready.
// Ports:
//  clk, reset_N          clock, async active-low reset
//  num_of_bbox_in_frame  bbox count N, sampled on an accepted start_write
//  start_write           start request (ignored while busy)
//  abort                 drop the sequence, no done
//  buf_ready             buffer accepts the current beat
//  wr_valid              beat valid
//  row_sel, grp_sel      PE row / LANES-group of the beat
//  lane_mask             valid lanes of the beat (LSB = lowest PE)
//  last_beat             final beat of the frame
//  busy                  LOAD..DONE inclusive
//  done                  one-cycle completion pulse
// ---------------------------------------------------------------------------
module oflow_core_write_sequencer
   import oflow_core_write_pkg::*;
#(
   parameter int PE_NUM = 22,
   parameter int LANES  = 4,
   parameter int BBOX_W = 10,
   parameter int ROW_W  = row_w_f(BBOX_W, PE_NUM),
   parameter int GRP_W  = grp_w_f(PE_NUM, LANES)
) (
   input  logic              clk,
   input  logic              reset_N,
   input  logic [BBOX_W-1:0] num_of_bbox_in_frame,
   input  logic              start_write,
   input  logic              abort,
   input  logic              buf_ready,
   output logic              wr_valid,
   output logic [ROW_W-1:0]  row_sel,
   output logic [GRP_W-1:0]  grp_sel,
   output logic [LANES-1:0]  lane_mask,
   output logic              last_beat,
   output logic              busy,
   output logic              done
);

   localparam int REM_W         = rem_w_f(PE_NUM);
   localparam int FULL_LAST_GRP = (PE_NUM + LANES - 1) / LANES - 1;

   wr_state_t         state;
   logic [BBOX_W-1:0] n_q;
   logic [ROW_W-1:0]  row;
   logic [GRP_W-1:0]  grp;
   logic [ROW_W-1:0]  full_rows;
   logic [REM_W-1:0]  rem;
   logic [GRP_W-1:0]  rem_last_grp;

   logic              in_part_row;
   logic [GRP_W-1:0]  row_last_grp;
   logic              last_grp;
   logic              last_row;
   logic              last_b;
   int                row_k;
   logic [LANES-1:0]  beat_mask;

   oflow_bbox_row_split #(
      .PE_NUM (PE_NUM),
      .LANES  (LANES),
      .BBOX_W (BBOX_W),
      .ROW_W  (ROW_W),
      .GRP_W  (GRP_W),
      .REM_W  (REM_W)
   ) u_row_split (
      .clk          (clk),
      .reset_N      (reset_N),
      .load         (state == LOAD),
      .n            (n_q),
      .full_rows    (full_rows),
      .rem          (rem),
      .rem_last_grp (rem_last_grp)
   );

   // Row index full_rows is the partial row; it is only ever reached when
   // rem > 0, so without a remainder the frame ends on row full_rows-1.
   always_comb begin
      in_part_row  = (row == full_rows);
      row_last_grp = in_part_row ? rem_last_grp : GRP_W'(FULL_LAST_GRP);
      last_grp     = (grp == row_last_grp);
      last_row     = (rem != '0) ? in_part_row : (row == full_rows - ROW_W'(1));
      row_k        = in_part_row ? int'(rem) : PE_NUM;
      last_b       = (state == BEAT) && last_grp && last_row;
      beat_mask    = {LANES{1'b1}};
      if (last_grp) beat_mask = LANES'(lane_mask_f(row_k - int'(grp) * LANES, LANES));
   end

   // Main sequencer. Abort outranks every transition; counters are cleared
   // whenever the sequence leaves the walk so outputs read zero when idle.
   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         state <= IDLE;
         n_q   <= '0;
         row   <= '0;
         grp   <= '0;
      end else if (abort && (state != IDLE)) begin
         state <= IDLE;
         row   <= '0;
         grp   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_write && !abort) begin
                  n_q   <= num_of_bbox_in_frame;
                  state <= LOAD;
               end
            end
            LOAD: begin
               row   <= '0;
               grp   <= '0;
               state <= (n_q == '0) ? DONE : ROW;
            end
            ROW: begin
               grp   <= '0;
               state <= BEAT;
            end
            BEAT: begin
               if (buf_ready) begin
                  if (last_b) begin
                     row   <= '0;
                     grp   <= '0;
                     state <= DONE;
                  end else if (last_grp) begin
                     row   <= row + ROW_W'(1);
                     grp   <= '0;
                     state <= ROW;
                  end else begin
                     grp   <= grp + GRP_W'(1);
                  end
               end
            end
            DONE: begin
               row   <= '0;
               grp   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Moore-style decode; nothing here looks at buf_ready.
   always_comb begin
      wr_valid  = (state == BEAT);
      busy      = (state != IDLE);
      done      = (state == DONE);
      row_sel   = row;
      grp_sel   = grp;
      last_beat = last_b;
      lane_mask = wr_valid ? beat_mask : '0;
   end

endmodule

// File: tb/tb_oflow_core_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_oflow_core_write_sequencer
// Directed bench for the write-back sequencer with PE_NUM=22, LANES=4,
// BBOX_W=10 (ROW_W=6, GRP_W=3). Outputs are packed into one vector
// {wr_valid,last_beat,busy,done,row_sel,grp_sel,lane_mask} and compared
// against hand-computed values one cycle at a time.
// ---------------------------------------------------------------------------
module tb_oflow_core_write_sequencer;

   logic       clk;
   logic       reset_N;
   logic [9:0] num_of_bbox_in_frame;
   logic       start_write;
   logic       abort;
   logic       buf_ready;
   logic       wr_valid;
   logic [5:0] row_sel;
   logic [2:0] grp_sel;
   logic [3:0] lane_mask;
   logic       last_beat;
   logic       busy;
   logic       done;

   int checks   = 0;
   int errors   = 0;
   int hsCount  = 0;
   int doneSeen = 0;

   oflow_core_write_sequencer #(
      .PE_NUM (22),
      .LANES  (4),
      .BBOX_W (10)
   ) dut (
      .clk                  (clk),
      .reset_N              (reset_N),
      .num_of_bbox_in_frame (num_of_bbox_in_frame),
      .start_write          (start_write),
      .abort                (abort),
      .buf_ready            (buf_ready),
      .wr_valid             (wr_valid),
      .row_sel              (row_sel),
      .grp_sel              (grp_sel),
      .lane_mask            (lane_mask),
      .last_beat            (last_beat),
      .busy                 (busy),
      .done                 (done)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count accepted beats and done pulses as seen at the active edge
   always @(posedge clk) begin
      if (wr_valid && buf_ready) hsCount++;
      if (done) doneSeen++;
   end

   // Hard stop so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL timeout: observed no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [16:0] ex(input logic v, input logic l, input logic b,
                                      input logic d, input int r, input int g,
                                      input logic [3:0] m);
      return {v, l, b, d, 6'(r), 3'(g), m};
   endfunction

   function automatic logic [16:0] outVec();
      return {wr_valid, last_beat, busy, done, row_sel, grp_sel, lane_mask};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [16:0] e);
      checkOutput(tag, 32'(outVec()), 32'(e));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [9:0] n);
      num_of_bbox_in_frame = n;
      start_write          = 1'b1;
      tick();
      start_write          = 1'b0;
   endtask

   // Checks and accepts every beat of one row with buf_ready held high
   task automatic runRow(input string tag, input int r, input int ngrp,
                         input logic [3:0] lastMask, input bit lastRow);
      for (int g = 0; g < ngrp; g++) begin
         checkState($sformatf("%s_r%0d_g%0d", tag, r, g),
                    ex(1'b1, lastRow && (g == ngrp - 1), 1'b1, 1'b0, r, g,
                       (g == ngrp - 1) ? lastMask : 4'hF));
         tick();
      end
   endtask

   // Directed sequence
   initial begin
      reset_N              = 1'b0;
      num_of_bbox_in_frame = '0;
      start_write          = 1'b0;
      abort                = 1'b0;
      buf_ready            = 1'b1;
      #12;
      checkState("reset", ex(0, 0, 0, 0, 0, 0, 4'h0));
      reset_N = 1'b1;
      tick();

      // N=0: LOAD then DONE, no beats
      $display("[TB] N=0");
      hsCount = 0;
      applyStimulus(10'd0);
      checkState("n0_load", ex(0, 0, 1, 0, 0, 0, 4'h0));
      tick();
      checkState("n0_done", ex(0, 0, 1, 1, 0, 0, 4'h0));
      tick();
      checkState("n0_idle", ex(0, 0, 0, 0, 0, 0, 4'h0));
      checkOutput("n0_beats", 32'(hsCount), 32'd0);

      // N=22: one full row, last group mask 4'b0011
      $display("[TB] N=22");
      applyStimulus(10'd22);
      checkState("n22_load", ex(0, 0, 1, 0, 0, 0, 4'h0));
      tick();
      checkState("n22_row", ex(0, 0, 1, 0, 0, 0, 4'h0));
      tick();
      runRow("n22", 0, 6, 4'h3, 1'b1);
      checkState("n22_done", ex(0, 0, 1, 1, 0, 0, 4'h0));
      tick();
      checkState("n22_idle", ex(0, 0, 0, 0, 0, 0, 4'h0));

      // N=49: two full rows plus partial row of 5
      $display("[TB] N=49");
      hsCount = 0;
      applyStimulus(10'd49);
      tick();
      for (int r = 0; r < 2; r++) begin
         checkState($sformatf("n49_row%0d", r), ex(0, 0, 1, 0, r, 0, 4'h0));
         tick();
         runRow("n49", r, 6, 4'h3, 1'b0);
      end
      checkState("n49_row2", ex(0, 0, 1, 0, 2, 0, 4'h0));
      tick();
      runRow("n49", 2, 2, 4'h1, 1'b1);
      checkState("n49_done", ex(0, 0, 1, 1, 0, 0, 4'h0));
      checkOutput("n49_beats", 32'(hsCount), 32'd14);
      tick();

      // N=8 with buf_ready toggling: outputs hold while stalled
      $display("[TB] N=8 backpressure");
      hsCount   = 0;
      buf_ready = 1'b0;
      applyStimulus(10'd8);
      tick();
      tick();
      checkState("n8_g0_stall", ex(1, 0, 1, 0, 0, 0, 4'hF));
      tick();
      checkState("n8_g0_hold", ex(1, 0, 1, 0, 0, 0, 4'hF));
      buf_ready = 1'b1;
      tick();
      buf_ready = 1'b0;
      checkState("n8_g1_stall", ex(1, 1, 1, 0, 0, 1, 4'hF));
      tick();
      checkState("n8_g1_hold", ex(1, 1, 1, 0, 0, 1, 4'hF));
      buf_ready = 1'b1;
      tick();
      checkState("n8_done", ex(0, 0, 1, 1, 0, 0, 4'h0));
      checkOutput("n8_beats", 32'(hsCount), 32'd2);
      tick();

      // N=49 aborted at row1 grp3: no done afterwards
      $display("[TB] abort");
      doneSeen = 0;
      applyStimulus(10'd49);
      tick();
      tick();
      runRow("ab", 0, 6, 4'h3, 1'b0);
      tick();
      for (int g = 0; g < 3; g++) tick();
      checkState("ab_r1_g3", ex(1, 0, 1, 0, 1, 3, 4'hF));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkState("ab_idle", ex(0, 0, 0, 0, 0, 0, 4'h0));
      tick();
      checkState("ab_still_idle", ex(0, 0, 0, 0, 0, 0, 4'h0));
      checkOutput("ab_no_done", 32'(doneSeen), 32'd0);

      // Fresh start after abort: N=4 is a single full-mask last beat
      applyStimulus(10'd4);
      tick();
      tick();
      checkState("n4_beat", ex(1, 1, 1, 0, 0, 0, 4'hF));
      tick();
      checkState("n4_done", ex(0, 0, 1, 1, 0, 0, 4'h0));
      tick();

      // start together with abort while idle is ignored
      num_of_bbox_in_frame = 10'd4;
      start_write          = 1'b1;
      abort                = 1'b1;
      tick();
      start_write = 1'b0;
      abort       = 1'b0;
      checkState("start_abort_idle", ex(0, 0, 0, 0, 0, 0, 4'h0));

      // start pulses during BEAT and DONE are ignored
      $display("[TB] start while busy");
      applyStimulus(10'd22);
      tick();
      tick();
      for (int g = 0; g < 6; g++) begin
         checkState($sformatf("busy_g%0d", g),
                    ex(1, g == 5, 1, 0, 0, g, (g == 5) ? 4'h3 : 4'hF));
         if (g == 2) begin
            num_of_bbox_in_frame = 10'd0;
            start_write          = 1'b1;
         end
         tick();
         start_write = 1'b0;
      end
      checkState("busy_done", ex(0, 0, 1, 1, 0, 0, 4'h0));
      start_write = 1'b1;
      tick();
      start_write = 1'b0;
      checkState("done_start_ignored", ex(0, 0, 0, 0, 0, 0, 4'h0));
      tick();
      checkState("done_start_no_load", ex(0, 0, 0, 0, 0, 0, 4'h0));

      // reset_N mid-BEAT clears outputs without waiting for a clock
      $display("[TB] reset mid-beat");
      applyStimulus(10'd49);
      tick();
      tick();
      tick();
      checkState("rst_pre", ex(1, 0, 1, 0, 0, 1, 4'hF));
      reset_N = 1'b0;
      #1;
      checkState("rst_async", ex(0, 0, 0, 0, 0, 0, 4'h0));
      #2;
      reset_N = 1'b1;
      tick();
      checkState("rst_after", ex(0, 0, 0, 0, 0, 0, 4'h0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
